serial_io_chain: RTL and testbench

Parametrised successor to the separate LED, DIP and 7-segment serial drivers. One engine drives a 74HC595-style output chain and reads a 74HC165-style input chain, with a shared serial clock.
- Widths, clock divider and bit order are configurable.
- Runs single-shot or continuous refresh.
- Reports change detection on input data.
- Sits between board serial pins and the CPU/IO registers.

---
 rtl/serial_io_chain_pkg.sv | 21 ++
 rtl/serial_io_chain_tick_gen.sv | 31 +++
 rtl/serial_io_chain.sv | 163 ++++++++++++++++
 tb/tb_serial_io_chain.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_io_chain_pkg.sv
// Shared definitions for the serial I/O chain engine: FSM state encodings and
// a width helper for sizing counters.
package serial_io_chain_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/serial_io_chain_tick_gen.sv
// Clock divider producing a one-cycle tick every CLK_DIV cycles while enabled;
// the count is held at zero whenever enable is low.
module tick_gen
    import serial_io_chain_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (!enable || count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign tick = enable && (count_reg == LAST);

endmodule

// File: rtl/serial_io_chain.sv
// Combined 74HC595 output / 74HC165 input chain driver sharing one serial clock,
// with single-shot or continuous refresh and input change detection.
module serial_io_chain
    import serial_io_chain_pkg::*;
#(
    parameter int OUT_WIDTH  = 16,
    parameter int IN_WIDTH   = 16,
    parameter int CLK_DIV    = 4,
    parameter int MSB_FIRST  = 1,
    parameter int CONTINUOUS = 1,
    parameter int GAP_TICKS  = 0
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET_n,
    input  logic                 i_Start,
    input  logic [OUT_WIDTH-1:0] i_OutData,
    input  logic                 i_SerIn,
    output logic                 o_SCLK,
    output logic                 o_SerOut,
    output logic                 o_OutLatch,
    output logic                 o_InLoad_n,
    output logic [IN_WIDTH-1:0]  o_InData,
    output logic                 o_InValid,
    output logic                 o_InChanged,
    output logic                 o_Busy
);

    localparam int FRAME = (OUT_WIDTH > IN_WIDTH) ? OUT_WIDTH : IN_WIDTH;
    localparam int PAD   = FRAME - OUT_WIDTH;
    localparam int BW    = clog2(FRAME + 1);
    localparam int GW    = clog2(GAP_TICKS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);

    logic [2:0]          state_reg;
    logic [BW-1:0]       bit_reg;
    logic                phase_reg;
    logic [GW-1:0]       gap_reg;
    logic [FRAME-1:0]    out_shift_reg;
    logic [IN_WIDTH-1:0] in_shift_reg;
    logic [FRAME-1:0]    frame_order;
    logic [IN_WIDTH-1:0] sample_sel;
    logic                tick;
    logic                start_fire;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (i_CLK),
        .reset_n (i_RESET_n),
        .enable  (state_reg != ST_IDLE),
        .tick    (tick)
    );

    // Output word rearranged into transmit order, first bit sent at the MSB.
    for (genvar gi = 0; gi < FRAME; gi++) begin : g_frame
        if (gi < PAD) begin : g_pad
            assign frame_order[FRAME-1-gi] = 1'b0;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign frame_order[FRAME-1-gi] = i_OutData[OUT_WIDTH-1-(gi-PAD)];
        end else begin : g_lsb
            assign frame_order[FRAME-1-gi] = i_OutData[gi-PAD];
        end
    end

    // One-hot destination of the current sample; samples past IN_WIDTH match nothing.
    for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_sample
        localparam int SAMPLE = (MSB_FIRST != 0) ? (IN_WIDTH - 1 - gi) : gi;
        assign sample_sel[gi] = (bit_reg == BW'(SAMPLE));
    end

    assign start_fire = (state_reg == ST_IDLE) && ((CONTINUOUS != 0) || i_Start) && i_RESET_n;
    assign o_Busy     = (state_reg != ST_IDLE) || start_fire;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_reg     <= ST_IDLE;
            bit_reg       <= '0;
            phase_reg     <= 1'b0;
            gap_reg       <= '0;
            out_shift_reg <= '0;
            in_shift_reg  <= '0;
            o_SCLK        <= 1'b0;
            o_SerOut      <= 1'b0;
            o_OutLatch    <= 1'b0;
            o_InLoad_n    <= 1'b1;
            o_InData      <= '0;
            o_InValid     <= 1'b0;
            o_InChanged   <= 1'b0;
        end else begin
            o_InValid   <= 1'b0;
            o_InChanged <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_fire) begin
                        out_shift_reg <= frame_order;
                        o_InLoad_n    <= 1'b0;
                        state_reg     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (tick) begin
                        o_InLoad_n    <= 1'b1;
                        o_SerOut      <= out_shift_reg[FRAME-1];
                        out_shift_reg <= out_shift_reg << 1;
                        bit_reg       <= '0;
                        phase_reg     <= 1'b0;
                        state_reg     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!phase_reg) begin
                            // Input is captured on the same edge that raises SCLK.
                            o_SCLK       <= 1'b1;
                            phase_reg    <= 1'b1;
                            in_shift_reg <= (in_shift_reg & ~sample_sel)
                                          | (sample_sel & {IN_WIDTH{i_SerIn}});
                        end else begin
                            o_SCLK    <= 1'b0;
                            phase_reg <= 1'b0;
                            if (bit_reg == LAST_BIT) begin
                                o_SerOut   <= 1'b0;
                                o_OutLatch <= 1'b1;
                                state_reg  <= ST_LATCH;
                            end else begin
                                bit_reg       <= bit_reg + BW'(1);
                                o_SerOut      <= out_shift_reg[FRAME-1];
                                out_shift_reg <= out_shift_reg << 1;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        o_OutLatch  <= 1'b0;
                        o_InData    <= in_shift_reg;
                        o_InValid   <= 1'b1;
                        o_InChanged <= (in_shift_reg != o_InData);
                        if (GAP_TICKS > 0) begin
                            gap_reg   <= GW'(GAP_TICKS);
                            state_reg <= ST_GAP;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (gap_reg <= GW'(1)) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            gap_reg <= gap_reg - GW'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_io_chain.sv
// Bench for serial_io_chain: four configurations, each attached to a behavioural
// 595/165 chain model, checked frame by frame against expectations built from the rules.
module tb_serial_io_chain;

    localparam int NI = 4;
    localparam int OW [NI] = '{8, 12, 4, 4};
    localparam int IW [NI] = '{8, 4, 12, 4};
    localparam int DV [NI] = '{2, 2, 3, 1};
    localparam int MF [NI] = '{1, 0, 1, 1};
    localparam int CT [NI] = '{0, 0, 0, 1};
    localparam int GP [NI] = '{0, 2, 0, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rst_n [NI];
    logic        start [NI];
    logic        ser_in [NI];
    logic        sclk [NI];
    logic        ser_out [NI];
    logic        latch [NI];
    logic        load_n [NI];
    logic        valid [NI];
    logic        changed [NI];
    logic        busy [NI];
    logic [15:0] out_data [NI];
    logic [15:0] in_word [NI];
    logic [15:0] in_data [NI];
    logic [31:0] prev [NI];

    // Monitor / chain-model state, written only by the negedge monitor below.
    logic [15:0] sh [NI];
    logic [31:0] sent [NI];
    logic        sclk_q [NI];
    int          nsclk [NI];
    int          nbusy [NI];
    int          nlatch [NI];
    int          nval [NI];
    int          nchg [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic [IW[gi]-1:0] in_data_w;
        serial_io_chain #(
            .OUT_WIDTH  (OW[gi]),
            .IN_WIDTH   (IW[gi]),
            .CLK_DIV    (DV[gi]),
            .MSB_FIRST  (MF[gi]),
            .CONTINUOUS (CT[gi]),
            .GAP_TICKS  (GP[gi])
        ) u_dut (
            .i_CLK       (clk),
            .i_RESET_n   (rst_n[gi]),
            .i_Start     (start[gi]),
            .i_OutData   (out_data[gi][OW[gi]-1:0]),
            .i_SerIn     (ser_in[gi]),
            .o_SCLK      (sclk[gi]),
            .o_SerOut    (ser_out[gi]),
            .o_OutLatch  (latch[gi]),
            .o_InLoad_n  (load_n[gi]),
            .o_InData    (in_data_w),
            .o_InValid   (valid[gi]),
            .o_InChanged (changed[gi]),
            .o_Busy      (busy[gi])
        );
        assign in_data[gi] = 16'(in_data_w);
    end

    // 165 model: parallel load while load_n low, shift toward Q7 on each SCLK rise
    // with the serial input tied high. Output side records every bit seen at an SCLK rise.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (busy[i]) nbusy[i]++;
            if (latch[i]) nlatch[i]++;
            if (valid[i]) nval[i]++;
            if (valid[i] && changed[i]) nchg[i]++;
            if (!load_n[i]) begin
                sh[i] = in_word[i];
            end else if (sclk[i] && !sclk_q[i]) begin
                nsclk[i]++;
                sent[i] = {sent[i][30:0], ser_out[i]};
                sh[i]   = (sh[i] << 1) | 16'h1;
            end
            sclk_q[i] = sclk[i];
            ser_in[i] = sh[i][IW[i]-1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < w; k++) r[w-1-k] = v[k];
        return r;
    endfunction

    function automatic logic [31:0] mask(input int w);
        return (32'h1 << w) - 32'h1;
    endfunction

    function automatic int frame_len(input int i);
        return (OW[i] > IW[i]) ? OW[i] : IW[i];
    endfunction

    // One single-shot frame; a second start pulse lands mid-frame and must be dropped.
    task automatic run_frame(input int i, input logic [15:0] d_in, input logic [15:0] p_in);
        logic [31:0] d, p, exp_in, exp_bits;
        int s_sclk, s_busy, s_latch, s_val, s_chg, fr, budget;
        d        = 32'(d_in) & mask(OW[i]);
        p        = 32'(p_in) & mask(IW[i]);
        fr       = frame_len(i);
        exp_in   = (MF[i] != 0) ? p : rev(p, IW[i]);
        exp_bits = (MF[i] != 0) ? d : rev(d, OW[i]);
        @(posedge clk);
        #1;
        out_data[i] = d[15:0];
        in_word[i]  = p[15:0];
        s_sclk = nsclk[i]; s_busy = nbusy[i]; s_latch = nlatch[i];
        s_val  = nval[i];  s_chg  = nchg[i];
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i]    = 1'b0;
        out_data[i] = ~d[15:0];
        repeat ($urandom_range(2, 20)) @(posedge clk);
        #1 start[i] = 1'b1;
        @(posedge clk);
        #1 start[i] = 1'b0;
        budget = 0;
        while (busy[i] && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        check($sformatf("busy_timeout%0d", i), 32'(budget >= 5000), 32'd0);
        repeat (10) @(negedge clk);
        check($sformatf("in_data%0d", i), 32'(in_data[i]), exp_in);
        check($sformatf("valid_pulses%0d", i), 32'(nval[i] - s_val), 32'd1);
        check($sformatf("changed_pulses%0d", i), 32'(nchg[i] - s_chg), 32'(exp_in != prev[i]));
        check($sformatf("sclk_edges%0d", i), 32'(nsclk[i] - s_sclk), 32'(fr));
        check($sformatf("ser_bits%0d", i), sent[i] & mask(fr), exp_bits);
        check($sformatf("latch_cycles%0d", i), 32'(nlatch[i] - s_latch), 32'(DV[i]));
        check($sformatf("busy_cycles%0d", i), 32'(nbusy[i] - s_busy),
              32'(DV[i] * (2 * fr + 2 + GP[i]) + 1));
        $display("inst%0d frame out=0x%0h in=0x%0h -> in_data=0x%0h", i, d, p, in_data[i]);
        prev[i] = exp_in;
    endtask

    // Abort instance 0 during bit 3 of a frame, then confirm it stays quiet until started.
    task automatic reset_mid_frame();
        int s_sclk, s_latch, s_val, s_busy, budget;
        s_latch = nlatch[0];
        s_sclk  = nsclk[0];
        @(posedge clk);
        #1;
        out_data[0] = 16'h00C3;
        in_word[0]  = 16'h0077;
        start[0]    = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        budget = 0;
        while ((nsclk[0] - s_sclk) < 4 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        check("shift_timeout", 32'(budget >= 1000), 32'd0);
        #2 rst_n[0] = 1'b0;
        #1;
        check("rst_sclk", 32'(sclk[0]), 32'd0);
        check("rst_serout", 32'(ser_out[0]), 32'd0);
        check("rst_latch", 32'(latch[0]), 32'd0);
        check("rst_load_n", 32'(load_n[0]), 32'd1);
        check("rst_in_data", 32'(in_data[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n[0] = 1'b1;
        s_val  = nval[0];
        s_busy = nbusy[0];
        repeat (40) @(negedge clk);
        check("abort_latch", 32'(nlatch[0] - s_latch), 32'd0);
        check("idle_valid", 32'(nval[0] - s_val), 32'd0);
        check("idle_busy", 32'(nbusy[0] - s_busy), 32'd0);
        $display("inst0 reset mid-frame, idle after release");
        prev[0] = '0;
    endtask

    initial begin
        int t [6];
        int budget;
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b1; start[i] = 1'b0;
            out_data[i] = '0; in_word[i] = '0; prev[i] = '0;
        end
        in_word[3]  = 16'h000A;
        out_data[3] = 16'h0006;
        #1;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_busy%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("reset_load_n%0d", i), 32'(load_n[i]), 32'd1);
            check($sformatf("reset_sclk%0d", i), 32'(sclk[i]), 32'd0);
            check($sformatf("reset_in_data%0d", i), 32'(in_data[i]), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;

        // Continuous instance: valid period and change detection.
        for (int k = 0; k < 6; k++) begin
            budget = 0;
            @(negedge clk);
            while (!valid[3] && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            check("valid_timeout3", 32'(budget >= 100), 32'd0);
            t[k] = cyc;
            if (k == 0) begin
                check("cont_in_data0", 32'(in_data[3]), 32'hA);
                check("cont_changed0", 32'(changed[3]), 32'd1);
            end else begin
                check($sformatf("cont_period%0d", k), 32'(t[k] - t[k-1]), 32'd14);
            end
            if (k == 1) check("cont_changed1", 32'(changed[3]), 32'd0);
            if (k == 2) in_word[3] = 16'h0005;
            if (k == 3) begin
                check("cont_in_data3", 32'(in_data[3]), 32'h5);
                check("cont_changed3", 32'(changed[3]), 32'd1);
            end
            $display("inst3 valid at cycle %0d in_data=0x%0h", t[k], in_data[3]);
        end

        run_frame(0, 16'h00A5, 16'h003C);
        run_frame(0, 16'($urandom), 16'h003C);
        run_frame(0, 16'($urandom), 16'($urandom));
        run_frame(0, 16'($urandom), 16'($urandom));
        reset_mid_frame();
        run_frame(0, 16'h005A, 16'h003C);

        run_frame(1, 16'h0ABC, 16'h0009);
        run_frame(1, 16'($urandom), 16'($urandom));
        run_frame(1, 16'($urandom), 16'($urandom));

        run_frame(2, 16'h000F, 16'($urandom));
        run_frame(2, 16'($urandom), 16'($urandom));
        run_frame(2, 16'($urandom), 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
